// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - function codes, MDU state enum and sign helper (shared by MDU_FAST_MULT_EN builds)
package mult_div_unit_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  // Magnitude of a value, treating it as two's complement only for signed ops.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - unsigned restoring divide, one quotient bit per step
module mdu_div_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] dvs;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Trial subtract of the divisor from the partial remainder with the next dividend bit shifted in.
  // The partial remainder is always below the divisor, so bit 32 of diff is a clean borrow flag.
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvs};
  end

  // Remainder/quotient shift registers: keep the difference when it did not borrow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= shifted[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - HI/LO multiply/divide unit; MDU_FAST_MULT_EN selects single-cycle multiply
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  fncode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  mdu_state_t state, next_state;

  logic            is_mul, is_div, is_signed_f;
  logic            latch_ops, do_step, fix_wr, mthi_wr, mtlo_wr, dz_wr, fast_wr, done_next;
  logic            op_is_div, neg_res, neg_rem;
  logic [CNT_W-1:0] cnt;
  logic [31:0]     mcand;
  logic [63:0]     prod;
  logic [32:0]     mul_sum;
  logic [31:0]     div_quo, div_rem;
  logic [31:0]     abs_a, abs_b;
  logic [63:0]     prod_fix;
  logic [31:0]     quo_fix, rem_fix;

  // Instruction decode and operand magnitudes.
  always_comb begin
    is_mul      = (fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU);
    is_div      = (fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU);
    is_signed_f = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
    abs_a       = abs32(op_a, is_signed_f);
    abs_b       = abs32(op_b, is_signed_f);
  end

`ifdef MDU_FAST_MULT_EN
  logic [63:0] fast_prod;
  // Full 64x64 product truncated to 64 bits is exact for sign- or zero-extended 32-bit operands.
  always_comb begin
    fast_prod = {{32{is_signed_f & op_a[31]}}, op_a} * {{32{is_signed_f & op_b[31]}}, op_b};
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    next_state = state;
    latch_ops  = 1'b0;
    do_step    = 1'b0;
    fix_wr     = 1'b0;
    mthi_wr    = 1'b0;
    mtlo_wr    = 1'b0;
    dz_wr      = 1'b0;
    fast_wr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_mul) begin
`ifdef MDU_FAST_MULT_EN
            fast_wr    = 1'b1;
`else
            latch_ops  = 1'b1;
            next_state = ST_ITER;
`endif
          end else if (is_div) begin
            if (op_b == 32'd0) begin
              dz_wr = 1'b1;
            end else begin
              latch_ops  = 1'b1;
              next_state = ST_ITER;
            end
          end else if (fncode == FUNCT_MTHI) begin
            mthi_wr = 1'b1;
          end else if (fncode == FUNCT_MTLO) begin
            mtlo_wr = 1'b1;
          end
        end
      end
      ST_ITER: begin
        do_step = 1'b1;
        if (cnt == CNT_W'(ITERATIONS - 1)) next_state = ST_FIX;
      end
      ST_FIX: begin
        fix_wr     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    done_next = fix_wr | mthi_wr | mtlo_wr | dz_wr | fast_wr;
  end

  // Shift-add multiplier step: add multiplicand into the upper half when the low bit is set, then shift right.
  always_comb begin
    mul_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
  end

  // Operand latch, sign flags, step counter and product register.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_is_div <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      prod      <= '0;
    end else if (latch_ops) begin
      op_is_div <= is_div;
      neg_res   <= is_signed_f & (op_a[31] ^ op_b[31]);
      neg_rem   <= is_signed_f & op_a[31];
      cnt       <= '0;
      mcand     <= abs_a;
      prod      <= {32'd0, abs_b};
    end else if (do_step) begin
      cnt <= cnt + CNT_W'(1);
      if (!op_is_div) prod <= {mul_sum, prod[31:1]};
    end
  end

  mdu_div_core u_div_core (
    .clk      (clk),
    .reset    (reset),
    .load     (latch_ops & is_div),
    .step     (do_step & op_is_div),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  // Sign correction: truncating division, so the remainder follows the dividend.
  always_comb begin
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -div_quo : div_quo;
    rem_fix  = neg_rem ? -div_rem : div_rem;
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_wr) begin
      if (op_is_div) {hi, lo} <= {rem_fix, quo_fix};
      else           {hi, lo} <= prod_fix;
    end else if (dz_wr) begin
      hi <= op_a;
      lo <= 32'hFFFF_FFFF;
    end else if (mthi_wr) begin
      hi <= op_a;
    end else if (mtlo_wr) begin
      lo <= op_a;
`ifdef MDU_FAST_MULT_EN
    end else if (fast_wr) begin
      {hi, lo} <= fast_prod;
`endif
    end
  end

  // Completion pulse, one cycle after HI/LO change.
  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= done_next;
  end

  // Busy and combinational read port.
  always_comb begin
    busy   = (state != ST_IDLE);
    result = (fncode == FUNCT_MFHI) ? hi : lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

`ifdef MDU_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  fncode;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo, result;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .fncode (fncode),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = m_hi;
    l = m_lo;
    case (fn)
      FUNCT_MULT: begin
        p = sa * sb;
        h = p[63:32];
        l = p[31:0];
      end
      FUNCT_MULTU: begin
        u = {32'd0, a} * {32'd0, b};
        h = u[63:32];
        l = u[31:0];
      end
      FUNCT_DIV: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else begin
          p = sa / sb;
          l = p[31:0];
          p = sa % sb;
          h = p[31:0];
        end
      end
      FUNCT_DIVU: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, input string tag);
    int lat, busyc, exp_lat;
    logic [31:0] eh, el;
    bit iter;
    model(fn, a, b, eh, el);
    if (fn == FUNCT_DIV || fn == FUNCT_DIVU) iter = (b != 32'd0);
    else iter = !FAST;
    exp_lat = iter ? 33 : 0;
    if (!b2b) @(negedge clk);
    fncode = fn;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    busyc = 0;
    while (!done && lat < 100) begin
      if (busy) busyc++;
      if (lat >= 1) begin
        fncode = 6'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
      end
      start = (lat == 5);
      @(posedge clk);
      #1;
      lat++;
    end
    start  = 1'b0;
    fncode = 6'h00;
    check({tag, ".done_seen"}, 64'(done), 64'd1);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_cycles"}, 64'(busyc), 64'(exp_lat));
    check({tag, ".hi"}, 64'(hi), 64'(eh));
    check({tag, ".lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [5:0]  fn;
    logic [31:0] a, b;
    int dc;
    logic [5:0] ops [4];
    ops[0] = FUNCT_MULT;
    ops[1] = FUNCT_MULTU;
    ops[2] = FUNCT_DIV;
    ops[3] = FUNCT_DIVU;

    reset = 1'b1; start = 1'b0; fncode = 6'h00; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);

    // undefined function code is ignored
    fncode = 6'h3F; op_a = 32'h1111_1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    repeat (3) begin @(negedge clk); if (done || busy) dc++; end
    check("bad_fn.no_done", 64'(dc), 64'd0);
    check("bad_fn.hi", 64'(hi), 64'd0);

    run_op(FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg");
    check("mult_neg.hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("mult_neg.lo_const", 64'(lo), 64'hFFFF_FFF1);
    @(posedge clk); #1;
    check("mult_neg.done_pulse_width", 64'(done), 64'd0);

    run_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    check("multu_max.hi_const", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max.lo_const", 64'(lo), 64'h0000_0001);

    run_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7");
    check("div_neg7.lo_const", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg7.hi_const", 64'(hi), 64'hFFFF_FFFF);

    run_op(FUNCT_DIVU, 32'd7, 32'd0, 1'b0, "divu_zero");
    check("divu_zero.hi_const", 64'(hi), 64'd7);
    check("divu_zero.lo_const", 64'(lo), 64'hFFFF_FFFF);

    run_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    check("div_ovf.lo_const", 64'(lo), 64'h8000_0000);
    check("div_ovf.hi_const", 64'(hi), 64'd0);

    // MTHI / MTLO and the combinational read port
    @(negedge clk);
    fncode = FUNCT_MTHI; op_a = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mthi.done", 64'(done), 64'd1);
    check("mthi.busy", 64'(busy), 64'd0);
    m_hi = 32'h1234_5678;
    fncode = FUNCT_MFHI;
    #1;
    check("mfhi.result", 64'(result), 64'(m_hi));
    @(negedge clk);
    fncode = FUNCT_MTLO; op_a = 32'hCAFE_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo.done", 64'(done), 64'd1);
    m_lo = 32'hCAFE_0001;
    fncode = FUNCT_MFLO;
    #1;
    check("mflo.result", 64'(result), 64'(m_lo));
    check("mtlo.hi_kept", 64'(hi), 64'(m_hi));
    // MFHI with start has no side effect
    @(negedge clk);
    fncode = FUNCT_MFHI; op_a = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mfhi_start.no_done", 64'(done), 64'd0);
    check("mfhi_start.hi", 64'(hi), 64'(m_hi));

    // back-to-back: second start issued in the done cycle of the first
    run_op(FUNCT_DIVU, 32'd1000, 32'd7, 1'b0, "b2b_first");
    run_op(FUNCT_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "b2b_second");

    for (int i = 0; i < 16; i++) begin
      fn = ops[$urandom_range(0, 3)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(fn, a, b, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    // reset in the middle of a divide aborts it
    run_op(FUNCT_MULTU, 32'h0001_0001, 32'h0001_0001, 1'b0, "pre_reset");
    @(negedge clk);
    fncode = FUNCT_DIVU; op_a = 32'd100; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.hi", 64'(hi), 64'd0);
    check("abort.lo", 64'(lo), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dc = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dc++; end
    check("abort.no_done_40", 64'(dc), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit that executes the HI/LO class of R-type instructions (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO). It consumes the 6-bit function code produced by the ALU control decoder, owns the architectural HI and LO registers, and sits beside the ALU in the execute stage. It exposes a busy/done handshake so the control path can stall while an iterative operation runs.

## Interface
Parameters:
- ITERATIONS, 32, number of iterative steps for multiply and divide; fixed at the datapath width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only when busy=0.
- fncode  input  6  function code from the ALU control decoder (FUNCT_* values).
- op_a  input  32  rs operand / dividend / multiplicand.
- op_b  input  32  rt operand / divisor / multiplier.
- busy  output  1  high while an iterative operation is in progress.
- done  output  1  one-cycle pulse when HI/LO have just been updated.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- result  output  32  read port: hi when fncode=FUNCT_MFHI, else lo; combinational.

## Operation
- Reset values: hi=0, lo=0, busy=0, done=0; the state machine enters IDLE.
- States: IDLE, ITER, FIX.
- IDLE with start=1:
  - MULT/MULTU/DIV/DIVU: latch op_a and op_b, record signedness, clear the step counter, go to ITER.
  - MTHI/MTLO: write op_a into hi/lo at this edge and pulse done in the next cycle. No busy.
  - MFHI/MFLO: no state change and no done pulse. Reads use result only.
  - Any other fncode: ignored, no done pulse.
- ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on the absolute values for signed ops. After step 31, go to FIX.
- FIX: apply the sign correction, write hi/lo, pulse done, return to IDLE.
  - Multiply sign rule: the 64-bit product is negated if the operand signs differ.
  - Divide sign rule: the quotient is negated if the signs differ. The remainder takes the sign of the dividend (truncating division).
- Result mapping: MULT/MULTU write {hi,lo} = 64-bit product. DIV/DIVU write lo = quotient and hi = remainder.
- Divide by zero (op_b=0): skip ITER. Write hi=op_a and lo=32'hFFFF_FFFF at the start edge, pulse done in the next cycle, and never assert busy. This applies to both the signed and unsigned forms.
- 0x8000_0000 DIV 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- start while busy=1: ignored. Changes on op_a, op_b or fncode during busy have no effect.

## Timing
- Iterative op:
  - Start is sampled at edge E0.
  - busy is high from after E0 through the cycle before E33.
  - hi/lo update at E33, and done=1 in the cycle following E33.
  - Back-to-back: a new start is accepted in the same cycle that done is high.
- MTHI/MTLO and divide-by-zero: 1-edge latency, busy stays 0.
- result: zero-cycle combinational read of the registered hi/lo.
- reset has priority over everything:
  - Asserting reset mid-operation aborts it.
  - It clears hi/lo, busy and done at that edge, and no done pulse follows.

## Configuration
- MDU_FAST_MULT_EN defined: MULT/MULTU use a single-cycle 64-bit multiplier.
  - hi/lo are written at the start edge, done is pulsed in the next cycle, and busy is never asserted for multiplies.
  - Divides are unchanged.
- MDU_FAST_MULT_EN undefined: multiplies use the 33-edge iterative path described above.

## Structure
- Shared package (package.v): FUNCT_MULT=6'h18, FUNCT_MULTU=6'h19, FUNCT_DIV=6'h1A, FUNCT_DIVU=6'h1B, FUNCT_MFHI=6'h10, FUNCT_MTHI=6'h11, FUNCT_MFLO=6'h12, FUNCT_MTLO=6'h13. The MDU state enum also goes in the package.
- One sub-module, mdu_div_core: the unsigned restoring-divide step datapath (remainder/quotient shift registers and a 33-bit subtract).
- The FSM, the sign handling, the multiplier and the HI/LO registers stay in mult_div_unit.

## Test plan
- Reset: hold reset for 2 cycles, then release -> hi=0, lo=0, busy=0, done=0; start with fncode=6'h3F produces no done.
- MULT of op_a=0xFFFF_FFFD (-3) and op_b=5 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
  - Without the macro: done exactly 33 edges after start, busy high for 33 cycles.
  - With the macro: done 1 edge after start.
- MULTU of 0xFFFF_FFFF by 0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV of -7 by 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
  - A second start issued at cycle 5 is ignored.
  - DIVU of 7 by 0 -> hi=7, lo=0xFFFF_FFFF, done after 1 edge, busy never set.
- MTHI with op_a=0x1234_5678, then fncode=FUNCT_MFHI -> result=0x1234_5678.
  - MTLO with op_a=0xCAFE_0001, then fncode=FUNCT_MFLO -> result=0xCAFE_0001.
- Start DIVU of 100 by 3 and assert reset at cycle 10 -> at that edge busy=0, hi=lo=0, and no done for the next 40 cycles.
